sar_compare_search: RTL and testbench

//  Successive-approximation search controller driving an external magnitude comparator
//  (gt/eq/lt outputs, e.g. the 3-bit comparator block). Drives trial operand A, reads
//  the comparator's relation flags, and determines the hidden operand B MSB-first.

---
 rtl/sar_compare_search.sv | 128 ++++++++++++
 tb/tb_sar_compare_search.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sar_compare_search.sv
// Successive-approximation search controller: drives a trial operand into an external
// magnitude comparator and resolves the hidden operand MSB-first from gt/eq/lt flags.
module sar_compare_search #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err,
  output logic [1:0]       state_dbg
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PROBE  = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   trial_q, trial_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         wait_q, wait_d;
  logic               found_q, found_d;
  logic               err_q, err_d;
  logic               flags_onehot;

  // Odd parity and not all three set means exactly one flag is high.
  assign flags_onehot = (cmp_gt ^ cmp_eq ^ cmp_lt) & ~(cmp_gt & cmp_eq & cmp_lt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      trial_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      wait_q   <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    result_d = result_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    found_d  = found_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          trial_d          = '0;
          trial_d[WIDTH-1] = 1'b1;
          idx_d            = IDX_W'(WIDTH - 1);
          wait_d           = SETTLE_W;
          err_d            = 1'b0;
          found_d          = 1'b0;
          result_d         = '0;
          state_d          = S_PROBE;
        end
      end
      S_PROBE, S_VERIFY: begin
        // Flags are only trusted on the last cycle of each settle window.
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else if (!flags_onehot) begin
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = trial_q;
          state_d  = S_DONE;
        end else if (state_q == S_VERIFY) begin
          result_d = trial_q;
          found_d  = cmp_eq;
          state_d  = S_DONE;
        end else if (cmp_eq) begin
          result_d = trial_q;
          found_d  = 1'b1;
          state_d  = S_DONE;
        end else begin
          if (cmp_lt) trial_d[idx_q] = 1'b0;
          wait_d = SETTLE_W;
          if (idx_q == '0) begin
            state_d = S_VERIFY;
          end else begin
            trial_d[idx_q - IDX_W'(1)] = 1'b1;
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    trial     = trial_q;
    result    = result_q;
    found     = found_q;
    err       = err_q;
    busy      = (state_q == S_PROBE) || (state_q == S_VERIFY);
    done      = (state_q == S_DONE);
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_sar_compare_search.sv
// Bench for sar_compare_search: two instances (SETTLE 0 and 2) search the same hidden
// target through behavioural comparators; results are checked against a closed-form model.
module tb_sar_compare_search;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] target;
  logic         inject;

  logic         a_gt, a_eq, a_lt, a_busy, a_done, a_found, a_err;
  logic [W-1:0] a_trial, a_result;
  logic [1:0]   a_state;
  logic         b_gt, b_eq, b_lt, b_busy, b_done, b_found, b_err;
  logic [W-1:0] b_trial, b_result;
  logic [1:0]   b_state;

  // Comparators; inject forces the illegal gt+lt combination.
  assign a_gt = inject | (target > a_trial);
  assign a_eq = !inject && (target == a_trial);
  assign a_lt = inject | (target < a_trial);
  assign b_gt = inject | (target > b_trial);
  assign b_eq = !inject && (target == b_trial);
  assign b_lt = inject | (target < b_trial);

  sar_compare_search #(.WIDTH(W), .SETTLE(0)) dut_a (
    .clk(clk), .reset(reset), .start(start),
    .cmp_gt(a_gt), .cmp_eq(a_eq), .cmp_lt(a_lt),
    .trial(a_trial), .busy(a_busy), .done(a_done), .result(a_result),
    .found(a_found), .err(a_err), .state_dbg(a_state)
  );

  sar_compare_search #(.WIDTH(W), .SETTLE(2)) dut_b (
    .clk(clk), .reset(reset), .start(start),
    .cmp_gt(b_gt), .cmp_eq(b_eq), .cmp_lt(b_lt),
    .trial(b_trial), .busy(b_busy), .done(b_done), .result(b_result),
    .found(b_found), .err(b_err), .state_dbg(b_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [W-1:0] obs_a_q[$];
  logic [W-1:0] obs_b_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Edge (counted from the start-sampling edge) at which done rises.
  function automatic int exp_edge(input int s, input logic [W-1:0] tgt, input bit bad);
    int k;
    if (bad) return s + 1;
    if (tgt == '0) return (W + 1) * (s + 1);
    k = W;
    for (int p = W - 1; p >= 0; p--) if (tgt[p]) k = W - p;
    return k * (s + 1);
  endfunction

  // Trial value during busy cycle c: known upper bits of target plus the bit under test.
  function automatic logic [W-1:0] exp_trial(input int s, input logic [W-1:0] tgt,
                                            input bit bad, input int c);
    int v, pos, pre;
    v = c / (s + 1);
    if (bad) return W'(1 << (W - 1));
    if (v >= W) return tgt;
    pos = W - 1 - v;
    pre = (int'(tgt) >> (pos + 1)) << (pos + 1);
    return W'(pre | (1 << pos));
  endfunction

  task automatic run_search(input logic [W-1:0] tgt, input bit bad, input bit mid_start);
    int n, ea, eb, edge_a, edge_b;
    bit fin_a, fin_b;
    logic [W-1:0] exp_res;
    ea = exp_edge(0, tgt, bad);
    eb = exp_edge(2, tgt, bad);
    exp_res = bad ? W'(1 << (W - 1)) : tgt;
    exp_a_q.delete(); exp_b_q.delete(); obs_a_q.delete(); obs_b_q.delete();
    for (int c = 0; c < ea; c++) exp_a_q.push_back(exp_trial(0, tgt, bad, c));
    for (int c = 0; c < eb; c++) exp_b_q.push_back(exp_trial(2, tgt, bad, c));
    target = tgt;
    inject = bad;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    n = 0; fin_a = 0; fin_b = 0; edge_a = -1; edge_b = -1;
    while (n < 100 && !(fin_a && fin_b && n > edge_a + 1 && n > edge_b + 1)) begin
      if (mid_start) start = (n == 1);
      if (!fin_a) begin
        if (a_done) begin
          fin_a = 1; edge_a = n;
          check("a_result", 32'(a_result), 32'(exp_res));
          check("a_found", 32'(a_found), 32'(!bad));
          check("a_err", 32'(a_err), 32'(bad));
        end else if (a_busy) obs_a_q.push_back(a_trial);
      end else if (n == edge_a + 1) begin
        check("a_done_pulse", 32'({a_done, a_busy}), 32'(0));
        check("a_result_hold", 32'(a_result), 32'(exp_res));
      end
      if (!fin_b) begin
        if (b_done) begin
          fin_b = 1; edge_b = n;
          check("b_result", 32'(b_result), 32'(exp_res));
          check("b_found", 32'(b_found), 32'(!bad));
          check("b_err", 32'(b_err), 32'(bad));
        end else if (b_busy) obs_b_q.push_back(b_trial);
      end else if (n == edge_b + 1) begin
        check("b_done_pulse", 32'({b_done, b_busy}), 32'(0));
        check("b_result_hold", 32'(b_result), 32'(exp_res));
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("a_done_edge", 32'(edge_a), 32'(ea));
    check("b_done_edge", 32'(edge_b), 32'(eb));
    check("a_trial_count", 32'(obs_a_q.size()), 32'(exp_a_q.size()));
    check("b_trial_count", 32'(obs_b_q.size()), 32'(exp_b_q.size()));
    for (int i = 0; i < exp_a_q.size() && i < obs_a_q.size(); i++)
      check("a_trial", 32'(obs_a_q[i]), 32'(exp_a_q[i]));
    for (int i = 0; i < exp_b_q.size() && i < obs_b_q.size(); i++)
      check("b_trial", 32'(obs_b_q[i]), 32'(exp_b_q[i]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, 32'({a_trial, a_result, a_busy, a_done, a_found, a_err}), 32'(0));
    check({tag, "_b"}, 32'({b_trial, b_result, b_busy, b_done, b_found, b_err}), 32'(0));
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    target = '0;
    inject = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    run_search(3'd5, 1'b0, 1'b0);
    run_search(3'd4, 1'b0, 1'b0);
    check("a_trial_after_early", 32'(a_trial), 32'(4));
    run_search(3'd0, 1'b0, 1'b0);
    run_search(3'd7, 1'b0, 1'b0);
    run_search(3'd6, 1'b1, 1'b0);
    run_search(3'd5, 1'b0, 1'b1);

    for (int r = 0; r < 30; r++) begin
      run_search(W'($urandom_range(0, (1 << W) - 1)), ($urandom_range(0, 7) == 0), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Reset in the middle of a search.
    target = 3'd7;
    inject = 1'b0;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    @(posedge clk); #1;
    reset  = 1'b1;
    @(posedge clk); #1;
    check_all_zero("mid_reset");
    reset  = 1'b0;
    @(posedge clk); #1;
    check_all_zero("post_reset_idle");
    run_search(3'd3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
